// File: rtl/softmax_exp_unit.sv
// Softmax numerator stage: buffers one signed vector, tracks its maximum, then
// streams lut[max - x_i] (clamped to 0 past the table) and the sum of those values.
//
// state | meaning
// LOAD  | accepting elements and LUT writes, tracking the running max
// EMIT  | streaming exp(x_i - x_max) with valid/ready, accumulating the sum
// DONE  | one cycle: sum_out/sum_valid presented, counters cleared
module softmax_exp_unit #(
    parameter int DW        = 8,
    parameter int VEC_LEN   = 16,
    parameter int LUT_DEPTH = 16,
    parameter int EXP_W     = 32,
    parameter int SUM_W     = EXP_W + $clog2(VEC_LEN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DW-1:0]                in_data,
    input  logic                         in_last,
    input  logic                         lut_wr_en,
    input  logic [$clog2(LUT_DEPTH)-1:0] lut_wr_addr,
    input  logic [EXP_W-1:0]             lut_wr_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [EXP_W-1:0]             out_exp,
    output logic [$clog2(VEC_LEN)-1:0]   out_idx,
    output logic                         sum_valid,
    output logic [SUM_W-1:0]             sum_out,
    output logic                         len_err,
    output logic                         busy
);
    localparam int AW = $clog2(LUT_DEPTH);
    localparam int IW = $clog2(VEC_LEN);
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {LOAD, EMIT, DONE} state_t;

    state_t state, state_nxt;

    logic [DW-1:0]        vbuf [VEC_LEN];
    logic [EXP_W-1:0]     lut  [LUT_DEPTH];
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        rd;
    logic signed [DW-1:0] max_val;
    logic [SUM_W-1:0]     acc;

    logic          accept;
    logic          hs;
    logic          last_hs;
    logic          load_out;
    logic [DW-1:0] rd_elem;
    logic [DW:0]   diff;
    logic [EXP_W-1:0] exp_val;

    // Sign-extend both operands so the difference never wraps; it is always >= 0.
    assign rd_elem = vbuf[rd[IW-1:0]];
    assign diff    = {max_val[DW-1], max_val} - {rd_elem[DW-1], rd_elem};
    assign exp_val = (diff < (DW+1)'(LUT_DEPTH)) ? lut[diff[AW-1:0]] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        hs        = out_valid && out_ready;
        last_hs   = 1'b0;
        load_out  = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (accept && (in_last || cnt == CW'(VEC_LEN - 1)))
                    state_nxt = EMIT;
            end
            EMIT: begin
                busy     = 1'b1;
                last_hs  = hs && ({1'b0, out_idx} == cnt - CW'(1));
                load_out = (!out_valid || out_ready) && (rd < cnt);
                if (last_hs)
                    state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Element buffer and LUT are storage only; they keep their contents across reset.
    always_ff @(posedge clk) begin
        if (accept)
            vbuf[cnt[IW-1:0]] <= in_data;
        if (lut_wr_en && state == LOAD)
            lut[lut_wr_addr] <= lut_wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            rd        <= '0;
            max_val   <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_exp   <= '0;
            out_idx   <= '0;
            sum_valid <= 1'b0;
            sum_out   <= '0;
            len_err   <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            len_err   <= 1'b0;
            if (accept) begin
                cnt <= cnt + CW'(1);
                if (cnt == '0 || $signed(in_data) > max_val)
                    max_val <= $signed(in_data);
                len_err <= (cnt == CW'(VEC_LEN - 1)) && !in_last;
            end
            if (hs)
                acc <= acc + SUM_W'(out_exp);
            if (load_out) begin
                out_valid <= 1'b1;
                out_exp   <= exp_val;
                out_idx   <= rd[IW-1:0];
                rd        <= rd + CW'(1);
            end else if (hs) begin
                out_valid <= 1'b0;
            end
            if (last_hs) begin
                sum_out   <= acc + SUM_W'(out_exp);
                sum_valid <= 1'b1;
            end
            if (state == DONE) begin
                cnt     <= '0;
                rd      <= '0;
                max_val <= '0;
                acc     <= '0;
            end
        end
    end

endmodule
